dispatch_unit: RTL and testbench

Dual-issue in-order dispatcher feeding the reservation-station side of the machine. Accepts up to two decoded instructions per cycle, renames source registers through a 4-entry register status table, allocates a free station tag (A*, M*, LD*, ST*) and drives the 40-bit `instbus1`/`instbus2` words consumed by the add, mult, load and store stations. Snoops `addbus`, `multbus`, `loadbus` and `storeack` to free stations and retire renames.

---
 rtl/dispatch_pkg.sv | 46 ++++
 rtl/station_pool.sv | 52 +++++
 rtl/dispatch_unit.sv | 109 ++++++++++
 tb/tb_dispatch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared opcodes, register/tag bases, field positions and decode helpers for the dispatcher.
// Pure declarations: no latency, no backpressure.
package dispatch_pkg;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULT  = 8'h04;

  localparam logic [7:0] REG_R0   = 8'h10;
  localparam logic [7:0] TAG_A0   = 8'h20;
  localparam logic [7:0] TAG_M0   = 8'h30;
  localparam logic [7:0] TAG_LD0  = 8'h40;
  localparam logic [7:0] TAG_ST0  = 8'h50;
  localparam logic [7:0] TAG_NONE = 8'h00;

  // fetch word {op, src1, src2, dest}; instbus prepends the station tag; result bus {tag, data}
  localparam int OP_LSB      = 24;
  localparam int S1_LSB      = 16;
  localparam int S2_LSB      = 8;
  localparam int DST_LSB     = 0;
  localparam int BUS_TAG_LSB = 32;

  typedef enum logic [2:0] {
    CLS_ADD  = 3'd0,
    CLS_MULT = 3'd1,
    CLS_LD   = 3'd2,
    CLS_ST   = 3'd3,
    CLS_NONE = 3'd4
  } dclass_e;

  function automatic dclass_e op_class(input logic [7:0] op);
    case (op)
      OP_ADD:   return CLS_ADD;
      OP_MULT:  return CLS_MULT;
      OP_LOAD:  return CLS_LD;
      OP_STORE: return CLS_ST;
      default:  return CLS_NONE;
    endcase
  endfunction

  function automatic logic is_reg(input logic [7:0] x);
    return x[7:2] == REG_R0[7:2];
  endfunction

endpackage

// File: rtl/station_pool.sv
// Busy tracker for one station class: frees on tag match, hands out the two lowest free tags.
// Allocation is combinational on the current cycle's frees; busy state updates on the next edge.
module station_pool
  import dispatch_pkg::*;
#(
  parameter int         COUNT = 2,
  parameter logic [7:0] BASE  = TAG_A0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] free_tag,
  input  logic [1:0] alloc_num,
  output logic [7:0] tag0,
  output logic [7:0] tag1,
  output logic [1:0] avail
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [COUNT-1:0] busy_q, busy_d, free_now;
  logic [IW-1:0]    idx0, idx1;
  logic [1:0]       n_free;

  always_comb begin
    free_now = '0;
    idx0     = '0;
    idx1     = '0;
    n_free   = '0;
    // a station whose tag is on the snooped bus counts as free right now
    for (int i = 0; i < COUNT; i++) begin
      free_now[i] = !busy_q[i] || (free_tag == BASE + 8'(i));
      if (free_now[i]) begin
        if (n_free == 2'd0)      idx0 = IW'(i);
        else if (n_free == 2'd1) idx1 = IW'(i);
        if (n_free != 2'd2) n_free = n_free + 2'd1;
      end
    end
    busy_d = busy_q & ~free_now;
    if (alloc_num != 2'd0) busy_d[idx0] = 1'b1;
    if (alloc_num == 2'd2) busy_d[idx1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign tag0  = BASE + 8'(idx0);
  assign tag1  = BASE + 8'(idx1);
  assign avail = n_free;

endmodule

// File: rtl/dispatch_unit.sv
// Dual-issue in-order dispatcher: renames sources, allocates stations, drives instbus1/2 one cycle later.
// fetch_ready is combinational; a slot stalls when its class has no free station or its opcode is unknown.
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int NUM_ADD  = 3,
  parameter int NUM_MULT = 2,
  parameter int NUM_LD   = 2,
  parameter int NUM_ST   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch1,
  input  logic [31:0] fetch2,
  input  logic [1:0]  fetch_valid,
  output logic [1:0]  fetch_ready,
  output logic [39:0] instbus1,
  output logic [39:0] instbus2,
  input  logic [39:0] addbus,
  input  logic [39:0] multbus,
  input  logic [39:0] loadbus,
  input  logic [7:0]  storeack
);

  logic [7:0]  free_tag [4];
  logic [1:0]  avail [4];
  logic [1:0]  alloc_num [4];
  logic [7:0]  ptag0 [4];
  logic [7:0]  ptag1 [4];
  logic [7:0]  rstat_q [4];
  logic [7:0]  rstat_d [4];
  logic [7:0]  rs_view [4];
  logic [39:0] instbus1_q, instbus1_d, instbus2_q, instbus2_d;
  logic [7:0]  op1, op2, d1, d2, tag1, tag2, s1a, s1b, s2a, s2b;
  dclass_e     cls1, cls2;
  logic        acc1, acc2, wr1, wr2;

  assign free_tag[0] = addbus[BUS_TAG_LSB +: 8];
  assign free_tag[1] = multbus[BUS_TAG_LSB +: 8];
  assign free_tag[2] = loadbus[BUS_TAG_LSB +: 8];
  assign free_tag[3] = storeack;

  station_pool #(.COUNT(NUM_ADD),  .BASE(TAG_A0))  u_add  (.clk(clk), .rst(rst), .free_tag(free_tag[0]), .alloc_num(alloc_num[0]), .tag0(ptag0[0]), .tag1(ptag1[0]), .avail(avail[0]));
  station_pool #(.COUNT(NUM_MULT), .BASE(TAG_M0))  u_mult (.clk(clk), .rst(rst), .free_tag(free_tag[1]), .alloc_num(alloc_num[1]), .tag0(ptag0[1]), .tag1(ptag1[1]), .avail(avail[1]));
  station_pool #(.COUNT(NUM_LD),   .BASE(TAG_LD0)) u_ld   (.clk(clk), .rst(rst), .free_tag(free_tag[2]), .alloc_num(alloc_num[2]), .tag0(ptag0[2]), .tag1(ptag1[2]), .avail(avail[2]));
  station_pool #(.COUNT(NUM_ST),   .BASE(TAG_ST0)) u_st   (.clk(clk), .rst(rst), .free_tag(free_tag[3]), .alloc_num(alloc_num[3]), .tag0(ptag0[3]), .tag1(ptag1[3]), .avail(avail[3]));

  always_comb begin
    op1  = fetch1[OP_LSB +: 8];
    op2  = fetch2[OP_LSB +: 8];
    d1   = fetch1[DST_LSB +: 8];
    d2   = fetch2[DST_LSB +: 8];
    cls1 = op_class(op1);
    cls2 = op_class(op2);

    acc1 = fetch_valid[0] && (cls1 != CLS_NONE) && (avail[cls1[1:0]] != 2'd0);
    acc2 = acc1 && fetch_valid[1] && (cls2 != CLS_NONE) &&
           ((cls2 == cls1) ? (avail[cls2[1:0]] == 2'd2) : (avail[cls2[1:0]] != 2'd0));
    tag1 = ptag0[cls1[1:0]];
    tag2 = (cls2 == cls1) ? ptag1[cls2[1:0]] : ptag0[cls2[1:0]];
    wr1  = acc1 && (op1 != OP_STORE) && is_reg(d1);
    wr2  = acc2 && (op2 != OP_STORE) && is_reg(d2);

    for (int c = 0; c < 4; c++) begin
      alloc_num[c] = {1'b0, acc1 && (cls1[1:0] == 2'(c))} + {1'b0, acc2 && (cls2[1:0] == 2'(c))};
    end

    // producers completing this cycle read as ready, both for renaming and for the next table
    for (int r = 0; r < 4; r++) begin
      rs_view[r] = rstat_q[r];
      if (rstat_q[r] == free_tag[0] || rstat_q[r] == free_tag[1] || rstat_q[r] == free_tag[2])
        rs_view[r] = REG_R0 + 8'(r);
    end

    s1a = is_reg(fetch1[S1_LSB +: 8]) ? rs_view[fetch1[S1_LSB +: 2]] : fetch1[S1_LSB +: 8];
    s1b = is_reg(fetch1[S2_LSB +: 8]) ? rs_view[fetch1[S2_LSB +: 2]] : fetch1[S2_LSB +: 8];
    s2a = is_reg(fetch2[S1_LSB +: 8]) ? rs_view[fetch2[S1_LSB +: 2]] : fetch2[S1_LSB +: 8];
    s2b = is_reg(fetch2[S2_LSB +: 8]) ? rs_view[fetch2[S2_LSB +: 2]] : fetch2[S2_LSB +: 8];
    if (wr1 && fetch2[S1_LSB +: 8] == d1) s2a = tag1;
    if (wr1 && fetch2[S2_LSB +: 8] == d1) s2b = tag1;

    rstat_d = rs_view;
    if (wr1) rstat_d[d1[1:0]] = tag1;
    if (wr2) rstat_d[d2[1:0]] = tag2;

    instbus1_d = acc1 ? {tag1, op1, s1a, s1b, d1} : 40'h0;
    instbus2_d = acc2 ? {tag2, op2, s2a, s2b, d2} : 40'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) rstat_q[r] <= REG_R0 + 8'(r);
      instbus1_q <= 40'h0;
      instbus2_q <= 40'h0;
    end else begin
      rstat_q    <= rstat_d;
      instbus1_q <= instbus1_d;
      instbus2_q <= instbus2_d;
    end
  end

  assign fetch_ready = {acc2, acc1};
  assign instbus1    = instbus1_q;
  assign instbus2    = instbus2_q;

  logic unused_bus_data;
  assign unused_bus_data = ^{addbus[31:0], multbus[31:0], loadbus[31:0]};

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit with a slot-sequential reference model checked every cycle.
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch1 = '0, fetch2 = '0;
  logic [1:0]  fetch_valid = '0;
  logic [1:0]  fetch_ready;
  logic [39:0] instbus1, instbus2;
  logic [39:0] addbus = '0, multbus = '0, loadbus = '0;
  logic [7:0]  storeack = '0;

  int total = 0;
  int bad   = 0;

  dispatch_unit #(.NUM_ADD(3), .NUM_MULT(2), .NUM_LD(2), .NUM_ST(2)) dut (
    .clk(clk), .rst(rst), .fetch1(fetch1), .fetch2(fetch2), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .instbus1(instbus1), .instbus2(instbus2),
    .addbus(addbus), .multbus(multbus), .loadbus(loadbus), .storeack(storeack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // class index: 0 add, 1 mult, 2 load, 3 store, -1 unknown
  function automatic int op_cls(input logic [7:0] op);
    case (op)
      8'h03: return 0;
      8'h04: return 1;
      8'h01: return 2;
      8'h02: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int cnt_of(input int c);
    return (c == 0) ? 3 : 2;
  endfunction

  function automatic logic [7:0] base_of(input int c);
    return 8'h20 + 8'(c * 16);
  endfunction

  // model state: which stations are taken, and what each register currently waits on
  bit          m_busy [4][16];
  logic [7:0]  m_rs [4];
  logic [39:0] exp_w1 = '0, exp_w2 = '0;

  always @(negedge clk) begin : model
    logic [7:0]  tg [4];
    logic [7:0]  rs_n [4];
    bit          busy_n [4][16];
    logic [1:0]  rdy;
    logic [39:0] w [2];
    logic [31:0] f;
    logic [7:0]  tag, sa, sb;
    int          c, k;
    bit          stop;

    if (rst) begin
      for (int a = 0; a < 4; a++) begin
        m_rs[a] = 8'h10 + 8'(a);
        for (int i = 0; i < 16; i++) m_busy[a][i] = 1'b0;
      end
      exp_w1 = '0;
      exp_w2 = '0;
    end

    tg[0] = addbus[39:32];
    tg[1] = multbus[39:32];
    tg[2] = loadbus[39:32];
    tg[3] = storeack;
    busy_n = m_busy;
    rs_n   = m_rs;

    // completions first: freed stations become allocatable, finished producers become ready
    for (int a = 0; a < 4; a++)
      for (int i = 0; i < cnt_of(a); i++)
        if (tg[a] == base_of(a) + 8'(i)) busy_n[a][i] = 1'b0;
    for (int r = 0; r < 4; r++)
      if (rs_n[r] != 8'h00 && (rs_n[r] == tg[0] || rs_n[r] == tg[1] || rs_n[r] == tg[2]))
        rs_n[r] = 8'h10 + 8'(r);

    // then the two slots in program order, each seeing the effects of the one before
    rdy  = 2'b00;
    w[0] = '0;
    w[1] = '0;
    stop = 1'b0;
    for (int s = 0; s < 2; s++) begin
      f = (s == 0) ? fetch1 : fetch2;
      c = op_cls(f[31:24]);
      if (!stop && fetch_valid[s] && c >= 0) begin
        k = -1;
        for (int i = 0; i < cnt_of(c); i++)
          if (!busy_n[c][i] && k < 0) k = i;
        if (k >= 0) begin
          busy_n[c][k] = 1'b1;
          tag = base_of(c) + 8'(k);
          sa  = (f[23:18] == 6'b000100) ? rs_n[f[17:16]] : f[23:16];
          sb  = (f[15:10] == 6'b000100) ? rs_n[f[9:8]]   : f[15:8];
          w[s] = {tag, f[31:24], sa, sb, f[7:0]};
          if (f[31:24] != 8'h02 && f[7:2] == 6'b000100) rs_n[f[1:0]] = tag;
          rdy[s] = 1'b1;
        end else stop = 1'b1;
      end else stop = 1'b1;
    end

    chk("fetch_ready", {38'b0, fetch_ready}, {38'b0, rdy});
    chk("instbus1", instbus1, exp_w1);
    chk("instbus2", instbus2, exp_w2);

    if (!rst) begin
      m_busy = busy_n;
      m_rs   = rs_n;
      exp_w1 = w[0];
      exp_w2 = w[1];
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] f1, input logic [31:0] f2,
                       input logic [7:0] at, input logic [7:0] mt, input logic [7:0] lt,
                       input logic [7:0] sa);
    @(posedge clk);
    #1;
    fetch_valid = v;
    fetch1      = f1;
    fetch2      = f2;
    addbus      = {at, 32'h0000_0001};
    multbus     = {mt, 32'h0000_0002};
    loadbus     = {lt, 32'heeee_eeee};
    storeack    = sa;
  endtask

  initial begin
    // reset state: both legal slots would be accepted
    fetch_valid = 2'b11;
    fetch1      = 32'h04121311;
    fetch2      = 32'h03111012;
    @(negedge clk);
    chk("reset_ready", {38'b0, fetch_ready}, 40'h3);
    chk("reset_bus1", instbus1, 40'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("pair_ready", {38'b0, fetch_ready}, 40'h3);

    // MULTI R1<-R2,R3 + ADD R2<-R1,R0, then ADD R3<-R1,R2 reads the new renames
    drive(2'b01, 32'h03111213, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("pair_bus1", instbus1, 40'h3004121311);
    chk("pair_bus2", instbus2, 40'h2003301012);
    // A0 broadcast while ADD R2<-R0,R0 dispatches: A0 is reused and R2 stays pending
    drive(2'b01, 32'h03101012, '0, 8'h20, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("rename_bus1", instbus1, 40'h2103302013);
    drive(2'b01, 32'h03121210, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("reuse_a0", instbus1, 40'h2003101012);
    drive(2'b00, '0, '0, 8'h20, 8'h30, 8'h00, 8'h00);
    @(negedge clk);
    chk("r2_pending", instbus1, 40'h2203202010);
    drive(2'b00, '0, '0, 8'h21, 8'h00, 8'h00, 8'h00);
    drive(2'b00, '0, '0, 8'h22, 8'h00, 8'h00, 8'h00);

    // three MULTIs: the third stalls until M0 is broadcast, then takes M0 that cycle
    drive(2'b01, 32'h04101011, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(2'b01, 32'h04101011, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(2'b01, 32'h04101011, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("mult_stall", {38'b0, fetch_ready}, 40'h0);
    drive(2'b01, 32'h04101011, '0, 8'h00, 8'h30, 8'h00, 8'h00);
    @(negedge clk);
    chk("mult_free_ready", {38'b0, fetch_ready}, 40'h1);
    drive(2'b00, '0, '0, 8'h00, 8'h31, 8'h00, 8'h00);
    @(negedge clk);
    chk("mult_reuse_m0", instbus1, 40'h3004101011);
    drive(2'b00, '0, '0, 8'h00, 8'h30, 8'h00, 8'h00);

    // LOAD R1, then ADD R3<-R1,R1 while LD0 broadcasts: both sources bypass to R1
    drive(2'b01, 32'h01120011, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(2'b01, 32'h03111113, '0, 8'h00, 8'h00, 8'h40, 8'h00);
    @(negedge clk);
    chk("load_bus1", instbus1, 40'h4001120011);
    drive(2'b01, 32'h01120011, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("bypass_bus1", instbus1, 40'h2003111113);
    drive(2'b00, '0, '0, 8'h20, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("ld0_reused", instbus1, 40'h4001120011);
    drive(2'b00, '0, '0, 8'h00, 8'h00, 8'h40, 8'h00);

    // stores fill both ST stations; a STORE+ADD pair then blocks entirely
    drive(2'b01, 32'h02101100, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(2'b01, 32'h02101100, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(2'b11, 32'h02101100, 32'h03101011, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("st_full_ready", {38'b0, fetch_ready}, 40'h0);
    drive(2'b11, 32'h02101100, 32'h03101011, 8'h00, 8'h00, 8'h00, 8'h50);
    @(negedge clk);
    chk("st_full_bus1", instbus1, 40'h0);
    chk("st_full_bus2", instbus2, 40'h0);
    chk("st_ack_ready", {38'b0, fetch_ready}, 40'h3);
    drive(2'b00, '0, '0, 8'h00, 8'h00, 8'h00, 8'h51);
    @(negedge clk);
    chk("st_ack_bus1", instbus1, 40'h5002101100);
    chk("st_ack_bus2", instbus2, 40'h2003101011);
    drive(2'b00, '0, '0, 8'h20, 8'h00, 8'h00, 8'h50);

    // unknown opcode never accepted, and blocks a younger slot behind it
    drive(2'b01, 32'h07101011, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("bad_op_stall", {38'b0, fetch_ready}, 40'h0);
    drive(2'b11, 32'h03101011, 32'h07101011, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("bad_op_slot2", {38'b0, fetch_ready}, 40'h1);
    drive(2'b00, '0, '0, 8'h20, 8'h00, 8'h00, 8'h00);

    // reset mid-burst clears the buses at once; the next pair gets A0/M0 again
    drive(2'b11, 32'h03101011, 32'h04121312, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(2'b11, 32'h03111113, 32'h04101010, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    chk("burst_live", {39'b0, instbus1 != 40'h0}, 40'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_bus1", instbus1, 40'h0);
    chk("rst_bus2", instbus2, 40'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    fetch_valid = 2'b11;
    fetch1      = 32'h03101011;
    fetch2      = 32'h04121312;
    drive(2'b00, '0, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("post_rst_bus1", instbus1, 40'h2003101011);
    chk("post_rst_bus2", instbus2, 40'h3004121312);

    drive(2'b00, '0, '0, 8'h20, 8'h30, 8'h00, 8'h00);
    drive(2'b00, '0, '0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
